branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Parametrised branch target buffer with per-entry saturating direction counters, used in the FETCH stage to redirect the PC. It is looked up every cycle with the fetch PC. It is trained from the EXEC stage with each resolved branch's PC, target and outcome. Entries are allocated on taken misses, using free-slot-first then round-robin replacement. It generalises the fixed 4-entry/2-bit predictor to configurable depth, address width and counter width, and adds a flush port and optional performance counters.

## Interface
- ENTRIES, 4, number of BTB entries (≥2, any integer)
- ADDR_W, 32, PC/target width in bits
- CTR_W, 2, direction counter width in bits (≥1)
- STAT_W, 16, width of each statistics counter (only with BTB_STATS_EN)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- f_valid  in  1  fetch lookup request this cycle
- f_pc  in  ADDR_W  fetch PC to look up
- f_hit  out  1  f_pc matches a valid entry (combinational)
- f_predict_valid  out  1  hit and counter predicts taken (combinational)
- f_predict_addr  out  ADDR_W  stored target on hit, else 0 (combinational)
- x_valid  in  1  resolved branch update this cycle
- x_pc  in  ADDR_W  PC of resolved branch
- x_target  in  ADDR_W  resolved target address
- x_taken  in  1  branch was actually taken
- flush  in  1  synchronous invalidate of all entries
- stat_lookups  out  STAT_W  count of f_valid cycles (BTB_STATS_EN only)
- stat_mispredicts  out  STAT_W  count of mispredicted updates (BTB_STATS_EN only)

## Operation
- Entry state: valid bit, tag (full ADDR_W PC), target (ADDR_W), counter (CTR_W). Invariant: at most one valid entry per tag.
- Lookup: f_hit = f_valid & some valid entry has tag == f_pc. A counter value ≥ 2^(CTR_W-1) means taken. When f_valid=0: f_hit, f_predict_valid and f_predict_addr are all 0.
- Update on a hit (x_valid, x_pc matches a valid entry):
  - Counter saturating-increments if x_taken, saturating-decrements otherwise. It never wraps past 2^CTR_W-1 or 0.
  - Target is overwritten with x_target only if x_taken.
- Update on a miss, x_taken=1: allocate an entry with valid=1, tag=x_pc, target=x_target, counter=2^(CTR_W-1) (weakly taken).
- Update on a miss, x_taken=0: no table change.
- Victim selection: the lowest-index invalid entry if one exists. Otherwise the entry at the round-robin pointer rr_ptr, after which rr_ptr advances by 1 and wraps from ENTRIES-1 to 0. rr_ptr does not move when a free slot is used.
- Flush: clears all valid bits and sets rr_ptr=0. Targets, tags and counters need not be cleared.

## Timing
- Lookup latency: 0 cycles (combinational from f_pc, f_valid and table state).
- Update latency: the table changes at the edge ending the x_valid cycle and is visible to lookups from the next cycle.
- Same-cycle lookup and update of the same PC: the lookup sees the pre-update state (no bypass).
- flush together with x_valid in the same cycle: flush wins and the update is discarded.
- Reset (asynchronous, any cycle, including mid-update): all valid=0, rr_ptr=0, statistics=0. Outputs f_hit=0, f_predict_valid=0, f_predict_addr=0. An update in flight at reset is lost.

## Configuration
- BTB_STATS_EN defined:
  - stat_lookups increments on every f_valid cycle.
  - stat_mispredicts increments on x_valid cycles whose update is not discarded by flush, when either: (hit and counter-taken ≠ x_taken before the update), or (miss and x_taken=1).
  - Both counters saturate at 2^STAT_W-1 and are not cleared by flush.
- BTB_STATS_EN undefined: the stat_* ports and their logic are absent.

## Test plan
- Reset, then f_valid=1, f_pc=0x100 -> f_hit=0, f_predict_valid=0, f_predict_addr=0.
- Update x_pc=0x100, x_target=0x200, x_taken=1; next cycle look up 0x100 -> f_hit=1, f_predict_valid=1, f_predict_addr=0x200 (counter=2). Two not-taken updates -> counter=0, f_predict_valid=0, f_hit=1.
- CTR_W=2: four taken updates on 0x100 -> counter saturates at 3. One not-taken -> counter=2, still predicted taken.
- ENTRIES=4: allocate 0x10, 0x20, 0x30, 0x40, then 0x50 -> 0x10 evicted (slot 0), rr_ptr=1. Then 0x60 -> 0x20 evicted.
- Same cycle: lookup 0x100 while the first taken update to 0x100 occurs -> f_hit=0 that cycle, 1 the next. Assert flush together with x_valid -> update discarded and all lookups miss.
- BTB_STATS_EN: 10 f_valid cycles plus 3 mispredicting updates -> stat_lookups=10, stat_mispredicts=3. Then flush -> counts unchanged. Then async reset mid-cycle -> both 0 immediately.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Branch target buffer: fully associative PC->target table with per-entry saturating direction counters.
// Optional saturating lookup/mispredict statistics are built when BTB_STATS_EN is defined.
module branch_target_buffer #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_valid,
  input  logic [ADDR_W-1:0] f_pc,
  output logic              f_hit,
  output logic              f_predict_valid,
  output logic [ADDR_W-1:0] f_predict_addr,
  input  logic              x_valid,
  input  logic [ADDR_W-1:0] x_pc,
  input  logic [ADDR_W-1:0] x_target,
  input  logic              x_taken,
  input  logic              flush
`ifdef BTB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispredicts
`endif
);

  localparam int unsigned      IDX_W    = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  logic [ENTRIES-1:0] valid_q;
  logic [ADDR_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr;

  logic             f_match;
  logic [IDX_W-1:0] f_idx;
  logic             x_match;
  logic [IDX_W-1:0] x_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] victim;
  logic             do_alloc;

  // Tags are unique among valid entries, so the first match is the only match.
  always_comb begin
    f_match    = 1'b0;
    f_idx      = '0;
    x_match    = 1'b0;
    x_idx      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!f_match && valid_q[i] && (tag_q[i] == f_pc)) begin
        f_match = 1'b1;
        f_idx   = IDX_W'(i);
      end
      if (!x_match && valid_q[i] && (tag_q[i] == x_pc)) begin
        x_match = 1'b1;
        x_idx   = IDX_W'(i);
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign victim   = free_found ? free_idx : rr_ptr;
  assign do_alloc = x_valid && !flush && !x_match && x_taken;

  assign f_hit           = f_valid && f_match;
  assign f_predict_valid = f_hit && ctr_q[f_idx][CTR_W-1];
  assign f_predict_addr  = f_hit ? target_q[f_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rr_ptr  <= '0;
    end else if (flush) begin
      valid_q <= '0;
      rr_ptr  <= '0;
    end else if (do_alloc) begin
      valid_q[victim] <= 1'b1;
      if (!free_found)
        rr_ptr <= (rr_ptr == IDX_W'(ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end

  // Payload is only meaningful under a valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (x_valid && !flush) begin
      if (x_match) begin
        if (x_taken) begin
          target_q[x_idx] <= x_target;
          if (ctr_q[x_idx] != CTR_MAX)
            ctr_q[x_idx] <= ctr_q[x_idx] + 1'b1;
        end else if (ctr_q[x_idx] != '0) begin
          ctr_q[x_idx] <= ctr_q[x_idx] - 1'b1;
        end
      end else if (x_taken) begin
        tag_q[victim]    <= x_pc;
        target_q[victim] <= x_target;
        ctr_q[victim]    <= CTR_WEAK;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic mispredict;

  assign mispredict = x_valid && !flush &&
                      (x_match ? (ctr_q[x_idx][CTR_W-1] != x_taken) : x_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (f_valid && (stat_lookups != '1))
        stat_lookups <= stat_lookups + 1'b1;
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer (4 entries, 32-bit PCs, 2-bit counters).
// Statistics checks are compiled in when BTB_STATS_EN is defined.
module tb_branch_target_buffer;

  localparam int unsigned ENTRIES = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned CTR_W   = 2;
  localparam int unsigned STAT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              f_valid = 1'b0;
  logic [ADDR_W-1:0] f_pc = '0;
  logic              f_hit;
  logic              f_predict_valid;
  logic [ADDR_W-1:0] f_predict_addr;
  logic              x_valid = 1'b0;
  logic [ADDR_W-1:0] x_pc = '0;
  logic [ADDR_W-1:0] x_target = '0;
  logic              x_taken = 1'b0;
  logic              flush = 1'b0;
`ifdef BTB_STATS_EN
  logic [STAT_W-1:0] stat_lookups;
  logic [STAT_W-1:0] stat_mispredicts;
`endif

  branch_target_buffer #(
    .ENTRIES(ENTRIES),
    .ADDR_W (ADDR_W),
    .CTR_W  (CTR_W),
    .STAT_W (STAT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_hit          (f_hit),
    .f_predict_valid(f_predict_valid),
    .f_predict_addr (f_predict_addr),
    .x_valid        (x_valid),
    .x_pc           (x_pc),
    .x_target       (x_target),
    .x_taken        (x_taken),
    .flush          (flush)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups    (stat_lookups),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string             tag;
    logic              hit;
    logic              pv;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One cycle: drive at posedge+1, compare lookup outputs at negedge.
  task automatic op(input logic fv, input logic [ADDR_W-1:0] fpc,
                    input logic xv, input logic [ADDR_W-1:0] xpc,
                    input logic [ADDR_W-1:0] xtgt, input logic xtk, input logic fl,
                    input logic eh, input logic ep, input logic [ADDR_W-1:0] ea,
                    input string tag);
    exp_t e;
    f_valid = fv; f_pc = fpc;
    x_valid = xv; x_pc = xpc; x_target = xtgt; x_taken = xtk;
    flush = fl;
    sb.push_back('{tag, eh, ep, ea});
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, ".hit"},  64'(f_hit),           64'(e.hit));
    check({e.tag, ".pv"},   64'(f_predict_valid), 64'(e.pv));
    check({e.tag, ".addr"}, 64'(f_predict_addr),  64'(e.addr));
    @(posedge clk); #1;
    f_valid = 1'b0; x_valid = 1'b0; flush = 1'b0; x_taken = 1'b0;
  endtask

  task automatic look(input logic [ADDR_W-1:0] pc, input logic eh, input logic ep,
                      input logic [ADDR_W-1:0] ea, input string tag);
    op(1'b1, pc, 1'b0, '0, '0, 1'b0, 1'b0, eh, ep, ea, tag);
  endtask

  task automatic upd(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] tgt, input logic tk);
    op(1'b0, '0, 1'b1, pc, tgt, tk, 1'b0, 1'b0, 1'b0, '0, "idle");
  endtask

  task automatic do_flush(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] tgt);
    op(1'b0, '0, 1'b1, pc, tgt, 1'b1, 1'b1, 1'b0, 1'b0, '0, "flush_idle");
  endtask

  // Assert reset between edges while a hitting lookup is presented.
  task automatic mid_reset(input logic [ADDR_W-1:0] pc, input string tag);
    f_valid = 1'b1; f_pc = pc;
    #2;
    check({tag, ".pre_hit"}, 64'(f_hit), 64'(1));
    rst_n = 1'b0;
    #1;
    check({tag, ".hit"},  64'(f_hit),           64'(0));
    check({tag, ".pv"},   64'(f_predict_valid), 64'(0));
    check({tag, ".addr"}, 64'(f_predict_addr),  64'(0));
`ifdef BTB_STATS_EN
    check({tag, ".stat_lookups"},     64'(stat_lookups),     64'(0));
    check({tag, ".stat_mispredicts"}, 64'(stat_mispredicts), 64'(0));
`endif
    @(posedge clk); #1;
    rst_n = 1'b1; f_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    look(32'h100, 1'b0, 1'b0, 32'h0, "reset_miss");

    // Allocation and counter walk on 0x100
    upd(32'h100, 32'h200, 1'b1);
    look(32'h100, 1'b1, 1'b1, 32'h200, "alloc_weak_taken");
    upd(32'h100, 32'h300, 1'b0);
    look(32'h100, 1'b1, 1'b0, 32'h200, "ctr1_nt_keeps_tgt");
    upd(32'h100, 32'h300, 1'b0);
    look(32'h100, 1'b1, 1'b0, 32'h200, "ctr0");
    upd(32'h100, 32'h300, 1'b0);
    upd(32'h100, 32'h300, 1'b1);
    look(32'h100, 1'b1, 1'b0, 32'h300, "ctr_floor_then_1");
    upd(32'h100, 32'h300, 1'b1);
    look(32'h100, 1'b1, 1'b1, 32'h300, "ctr2");
    for (int i = 0; i < 3; i++) upd(32'h100, 32'h300, 1'b1);
    upd(32'h100, 32'h300, 1'b0);
    look(32'h100, 1'b1, 1'b1, 32'h300, "ctr_sat_then_2");
    upd(32'h100, 32'h300, 1'b0);
    look(32'h100, 1'b1, 1'b0, 32'h300, "ctr1_after_sat");
    look(32'h104, 1'b0, 1'b0, 32'h0, "neighbour_miss");
    op(1'b0, 32'h100, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, "fvalid0_gates");

    // Flush with a concurrent update: update discarded
    do_flush(32'h500, 32'h600);
    look(32'h100, 1'b0, 1'b0, 32'h0, "flush_clears");
    look(32'h500, 1'b0, 1'b0, 32'h0, "flush_drops_update");

    // Replacement: free slots, then round robin
    for (int i = 1; i <= 4; i++) upd(32'(i * 16), 32'(32'h1000 + i), 1'b1);
    upd(32'h50, 32'h1005, 1'b1);
    look(32'h10, 1'b0, 1'b0, 32'h0, "rr_evict_slot0");
    look(32'h50, 1'b1, 1'b1, 32'h1005, "rr_new_50");
    look(32'h20, 1'b1, 1'b1, 32'h1002, "rr_keep_20");
    upd(32'h60, 32'h1006, 1'b1);
    look(32'h20, 1'b0, 1'b0, 32'h0, "rr_evict_slot1");
    look(32'h30, 1'b1, 1'b1, 32'h1003, "rr_keep_30");
    look(32'h60, 1'b1, 1'b1, 32'h1006, "rr_new_60");
    upd(32'h70, 32'h1007, 1'b0);
    look(32'h70, 1'b0, 1'b0, 32'h0, "nt_miss_no_alloc");
    upd(32'h30, 32'h2003, 1'b1);
    upd(32'h80, 32'h1008, 1'b1);
    look(32'h30, 1'b0, 1'b0, 32'h0, "hit_update_no_rr_move");
    look(32'h40, 1'b1, 1'b1, 32'h1004, "rr_keep_40");

    // Flush resets rr_ptr: after refill the fifth allocation evicts slot 0
    do_flush(32'h0, 32'h0);
    for (int i = 0; i < 4; i++) upd(32'(32'hA0 + i * 16), 32'(32'h3000 + i), 1'b1);
    upd(32'hE0, 32'h3004, 1'b1);
    look(32'hA0, 1'b0, 1'b0, 32'h0, "flush_rr_evict_slot0");
    look(32'hC0, 1'b1, 1'b1, 32'h3002, "flush_rr_keep_c0");
    look(32'hE0, 1'b1, 1'b1, 32'h3004, "flush_rr_new_e0");

    // Same-cycle lookup and update: no bypass
    do_flush(32'h0, 32'h0);
    op(1'b1, 32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "same_cycle_miss");
    look(32'h100, 1'b1, 1'b1, 32'h200, "next_cycle_hit");
    op(1'b1, 32'h100, 1'b1, 32'h100, 32'h900, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, "same_cycle_pre_state");
    look(32'h100, 1'b1, 1'b0, 32'h200, "post_update_state");

    // Asynchronous reset with live table and counters
    mid_reset(32'h100, "async_reset1");
    look(32'h100, 1'b0, 1'b0, 32'h0, "after_reset_miss");

`ifdef BTB_STATS_EN
    upd(32'h10, 32'h20, 1'b1);
    mid_reset(32'h10, "stats_zero");
    for (int i = 0; i < 10; i++) look(32'(32'h8000 + i * 4), 1'b0, 1'b0, 32'h0, "stat_look");
    upd(32'h10, 32'h20, 1'b1);
    upd(32'h10, 32'h20, 1'b0);
    upd(32'h10, 32'h20, 1'b1);
    upd(32'h10, 32'h20, 1'b1);
    check("stat_lookups", 64'(stat_lookups), 64'(10));
    check("stat_mispredicts", 64'(stat_mispredicts), 64'(3));
    do_flush(32'h900, 32'h904);
    check("stat_lookups_flush", 64'(stat_lookups), 64'(10));
    check("stat_mispredicts_flush", 64'(stat_mispredicts), 64'(3));
    upd(32'h10, 32'h20, 1'b1);
    mid_reset(32'h10, "stats_async_reset");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
